rv_fetch_bus_resp: RTL and testbench
====================================

# rv_fetch_bus_resp

Responder side of the core's instruction-fetch bus: accepts one fetch request at a time from the fetch stage and reads a word from a synchronous instruction SRAM. It inserts a configurable number of wait states, then returns the word with a one-cycle acknowledge. That acknowledge drives the fetch-bus ack consumed by the pipeline control unit. Sits between the fetch stage and the instruction memory, and also flags misaligned or out-of-range fetches.

## Interface

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of memory word 0; must be aligned to 4·2^DEPTH_LOG2.
- DEPTH_LOG2, 12, log2 of memory depth in 32-bit words (1..20).
- WAIT_STATES, 1, extra idle cycles before the memory read (0..15).

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset_n  in  1  reset, asynchronous and active-low.
- i_cmd  in  1  fetch request; sampled only when the block can accept a request (see Operation).
- i_addr  in  32  fetch byte address, sampled with i_cmd.
- i_flush  in  1  abort in-flight request (branch/jump taken).
- o_ack  out  1  response valid, exactly one cycle per completed request.
- o_err  out  1  qualifies o_ack: misaligned or out-of-range fetch.
- o_data  out  32  instruction word; held stable from o_ack until the next o_ack.
- o_busy  out  1  high whenever state ≠ IDLE.
- o_mem_rd  out  1  SRAM read strobe.
- o_mem_addr  out  DEPTH_LOG2  SRAM word address.
- i_mem_data  in  32  SRAM read data, valid the cycle after o_mem_rd.

## Operation

- States: IDLE, WAIT, ISSUE, DATA, ACK.
- A request is accepted when state is IDLE or ACK, i_cmd=1 and i_flush=0.
- On acceptance:
  - latch i_addr into r_addr;
  - compute err = (i_addr[1:0]≠0) or (i_addr[31:DEPTH_LOG2+2] ≠ BASE_ADDR[31:DEPTH_LOG2+2]).
- Transitions from acceptance:
  - err=1 → ACK, with o_err=1 and o_data=32'h0000_0000 (decodes as an illegal instruction). No SRAM access.
  - WAIT_STATES>0 → WAIT, with the wait counter loaded with WAIT_STATES-1.
  - otherwise → ISSUE.
- WAIT: counter decrements each cycle; at 0 → ISSUE. Counter width is clog2(16)=4 bits and never wraps.
- ISSUE: o_mem_rd=1 and o_mem_addr=r_addr[DEPTH_LOG2+1:2] for exactly one cycle → DATA.
- DATA: capture i_mem_data into o_data at the closing edge; set o_ack=1 and o_err=0 for the next cycle → ACK.
- ACK: o_ack=1 for one cycle.
  - Next state is WAIT, ISSUE or ACK if a new request is accepted in this cycle.
  - Otherwise next state is IDLE.
- i_cmd in WAIT, ISSUE or DATA is ignored; the requester holds i_cmd/i_addr until it sees o_ack.
- i_flush:
  - In WAIT, ISSUE or DATA: next state is IDLE, no o_ack is produced, and o_data is unchanged.
  - If the SRAM read is already issued, its data is discarded.
  - In IDLE or ACK: blocks acceptance of i_cmd in the same cycle. An o_ack already asserted still completes, and the requester discards it.
- o_mem_addr holds its last value when o_mem_rd=0.
- All outputs are registered; no combinational path from any input to any output.

## Timing

- Reset (async assert, sync deassert by the system): state=IDLE, counter=0.
- Reset values: o_ack=0, o_err=0, o_data=0, o_busy=0, o_mem_rd=0, o_mem_addr=0.
- Reset mid-request drops the request immediately; no o_ack follows.
- Request accepted in cycle N:
  - o_mem_rd is high in cycle N+WAIT_STATES+1;
  - o_ack is high in cycle N+WAIT_STATES+3.
- Error response: o_ack and o_err are high in cycle N+1.
- Back-to-back: a request accepted in the ACK cycle M gives its o_ack in M+WAIT_STATES+3, so sustained throughput is one word per WAIT_STATES+3 cycles.
- o_busy rises in N+1 and falls the cycle after the final ACK, unless a new request was accepted.

## Test plan

- Reset with WAIT_STATES=1, SRAM word 5 = 32'h0050_0093, i_cmd with i_addr=32'h14 in cycle 0:
  - o_mem_rd=1 and o_mem_addr=5 in cycle 2;
  - o_ack=1, o_err=0, o_data=32'h0050_0093 in cycle 4 only.
- WAIT_STATES=0, i_cmd held continuously, addresses 0, 4, 8: one ack every 3 cycles, in cycles 3, 6 and 9, each with the matching SRAM word.
- i_addr=32'h0000_0002 → ack with err=1, o_data=0 in cycle 1, o_mem_rd never asserted. Repeat with i_addr=32'h0001_0000 (DEPTH_LOG2=12) → same result.
- WAIT_STATES=3, i_flush pulsed in the WAIT, ISSUE and DATA cycles (separate runs):
  - no o_ack, and o_data keeps its previous value;
  - the next request completes normally.
- i_flush and i_cmd together in the ACK cycle: the current ack is visible and the new request is not accepted (o_busy=0 next cycle).
- i_reset_n dropped in the DATA cycle: all outputs are 0 asynchronously and no ack is produced after release.

Source files
------------

// File: rtl/rv_fetch_bus_resp.sv
// rv_fetch_bus_resp
// Responder for the instruction-fetch bus. It takes one fetch at a time,
// optionally idles for WAIT_STATES cycles, reads one word from a synchronous
// SRAM and returns it with a single-cycle acknowledge. Misaligned fetches and
// fetches outside the memory window are answered at once with o_err set and
// an all-zero word, which the decoder treats as an illegal instruction.
// A flush drops whatever is in flight; nothing is acknowledged for it.
module rv_fetch_bus_resp #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_LOG2  = 12,
    parameter int          WAIT_STATES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_cmd,
    input  logic [31:0]           i_addr,
    input  logic                  i_flush,
    output logic                  o_ack,
    output logic                  o_err,
    output logic [31:0]           o_data,
    output logic                  o_busy,
    output logic                  o_mem_rd,
    output logic [DEPTH_LOG2-1:0] o_mem_addr,
    input  logic [31:0]           i_mem_data
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DATA  = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    // Address bits above the memory window must match the base address.
    localparam logic [31:0] HI_MASK   = ~((32'd1 << (DEPTH_LOG2 + 2)) - 32'd1);
    // The wait counter starts one below WAIT_STATES so that WAIT lasts
    // exactly WAIT_STATES cycles; guarded so WAIT_STATES=0 stays legal.
    localparam int          WAIT_M1   = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_M1);
    localparam bit          HAS_WAIT  = (WAIT_STATES > 0);

    state_t                state_r;
    logic [3:0]            wait_cnt_r;
    logic [DEPTH_LOG2-1:0] word_addr_r;

    // Misaligned or outside the SRAM window.
    function automatic logic fetch_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr & HI_MASK) != (BASE_ADDR & HI_MASK));
    endfunction

    // Request sequencing FSM; every output is a register loaded here.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 4'd0;
            word_addr_r <= '0;
            o_ack       <= 1'b0;
            o_err       <= 1'b0;
            o_data      <= 32'h0000_0000;
            o_busy      <= 1'b0;
            o_mem_rd    <= 1'b0;
            o_mem_addr  <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            o_ack    <= 1'b0;
            o_err    <= 1'b0;
            o_mem_rd <= 1'b0;

            case (state_r)
                // IDLE and ACK both accept a new request; a flush blocks it.
                ST_IDLE, ST_ACK: begin
                    if (i_cmd && !i_flush) begin
                        word_addr_r <= i_addr[DEPTH_LOG2+1:2];
                        o_busy      <= 1'b1;
                        if (fetch_err(i_addr)) begin
                            state_r <= ST_ACK;
                            o_ack   <= 1'b1;
                            o_err   <= 1'b1;
                            o_data  <= 32'h0000_0000;
                        end else if (HAS_WAIT) begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= WAIT_INIT;
                        end else begin
                            state_r    <= ST_ISSUE;
                            o_mem_rd   <= 1'b1;
                            o_mem_addr <= i_addr[DEPTH_LOG2+1:2];
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    if (i_flush) begin
                        state_r <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end else if (wait_cnt_r == 4'd0) begin
                        state_r    <= ST_ISSUE;
                        o_mem_rd   <= 1'b1;
                        o_mem_addr <= word_addr_r;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end

                // The read strobe is already on the bus this cycle; a flush
                // here only causes the returning word to be ignored.
                ST_ISSUE: begin
                    if (i_flush) begin
                        state_r <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (i_flush) begin
                        state_r <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end else begin
                        state_r <= ST_ACK;
                        o_data  <= i_mem_data;
                        o_ack   <= 1'b1;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_fetch_bus_resp.sv
// Bench for rv_fetch_bus_resp. Two instances share the request inputs: one
// with two wait states, one with none. A transaction-level reference model
// (accept cycle + fixed latency) predicts every output of both each cycle;
// directed vectors and short hand sequences cover the corner cases.
module tb_rv_fetch_bus_resp;

    localparam int DL   = 12;
    localparam int WS_A = 2;
    localparam int WS_B = 0;
    localparam int NW   = (1 << DL);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 cmd;
    logic                 flush;
    logic [31:0]          addr;
    logic [1:0]           ack_v, err_v, busy_v, rd_v;
    logic [1:0][DL-1:0]   maddr_v;
    logic [1:0][31:0]     data_v;
    logic [1:0][31:0]     memq_v;
    logic [31:0]          mem [0:NW-1];

    rv_fetch_bus_resp #(.BASE_ADDR(32'h0000_0000), .DEPTH_LOG2(DL), .WAIT_STATES(WS_A)) u_dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_cmd(cmd), .i_addr(addr), .i_flush(flush),
        .o_ack(ack_v[0]), .o_err(err_v[0]), .o_data(data_v[0]), .o_busy(busy_v[0]),
        .o_mem_rd(rd_v[0]), .o_mem_addr(maddr_v[0]), .i_mem_data(memq_v[0])
    );

    rv_fetch_bus_resp #(.BASE_ADDR(32'h0000_0000), .DEPTH_LOG2(DL), .WAIT_STATES(WS_B)) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_cmd(cmd), .i_addr(addr), .i_flush(flush),
        .o_ack(ack_v[1]), .o_err(err_v[1]), .o_data(data_v[1]), .o_busy(busy_v[1]),
        .o_mem_rd(rd_v[1]), .o_mem_addr(maddr_v[1]), .i_mem_data(memq_v[1])
    );

    // Synchronous SRAM per instance; data is garbage unless a read was issued.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            memq_v[k] <= rd_v[k] ? mem[maddr_v[k]] : $urandom;
        end
    end

    int errors;
    int checks;
    int cyc;

    // Reference model: one pending transaction per instance.
    bit            m_pend  [2];
    int            m_acc   [2];
    bit            m_err   [2];
    logic [DL-1:0] m_word  [2];
    logic [31:0]   m_data  [2];
    logic [DL-1:0] m_maddr [2];
    logic          e_ack [2], e_err [2], e_busy [2], e_rd [2];
    logic [31:0]   e_data  [2];
    logic [DL-1:0] e_maddr [2];

    typedef struct {
        logic          cmd;
        logic          flush;
        logic [31:0]   addr;
        logic          ack;
        logic          err;
        logic          busy;
        logic          rd;
        logic [DL-1:0] maddr;
        logic [31:0]   data;
    } vec_t;
    vec_t tbl [16];

    logic [31:0] held;
    bit          got;
    int          flist [3];

    function automatic int ws_of(input int k);
        return (k == 0) ? WS_A : WS_B;
    endfunction

    function automatic int done_of(input int k);
        return m_acc[k] + (m_err[k] ? 1 : ws_of(k) + 3);
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 32'd4 != 32'd0) || (a >= (32'd4 << DL));
    endfunction

    task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got_v, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = 1'b0;
            m_acc[k]   = 0;
            m_err[k]   = 1'b0;
            m_word[k]  = '0;
            m_data[k]  = 32'h0;
            m_maddr[k] = '0;
        end
    endtask

    // Sample mid-cycle and compare both instances against the model.
    task automatic sample();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e_ack[k]   = m_pend[k] && (cyc == done_of(k));
            e_err[k]   = e_ack[k] && m_err[k];
            e_rd[k]    = m_pend[k] && !m_err[k] && (cyc == m_acc[k] + ws_of(k) + 1);
            e_busy[k]  = m_pend[k];
            e_data[k]  = e_ack[k] ? (m_err[k] ? 32'h0 : mem[m_word[k]]) : m_data[k];
            e_maddr[k] = e_rd[k] ? m_word[k] : m_maddr[k];
            check($sformatf("model_%0d", k),
                  {16'h0, ack_v[k], err_v[k], busy_v[k], rd_v[k], maddr_v[k], data_v[k]},
                  {16'h0, e_ack[k], e_err[k], e_busy[k], e_rd[k], e_maddr[k], e_data[k]});
        end
    endtask

    // Apply this cycle's inputs to the model, then move to the next cycle.
    task automatic advance();
        for (int k = 0; k < 2; k++) begin
            m_data[k]  = e_data[k];
            m_maddr[k] = e_maddr[k];
            if (!m_pend[k] || (cyc == done_of(k))) begin
                if (cmd && !flush) begin
                    m_pend[k] = 1'b1;
                    m_acc[k]  = cyc;
                    m_err[k]  = addr_bad(addr);
                    m_word[k] = addr[DL+1:2];
                end else begin
                    m_pend[k] = 1'b0;
                end
            end else if (flush) begin
                m_pend[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        cmd = 1'b0; flush = 1'b0; addr = 32'h0;
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cmd = 1'b0; flush = 1'b0; addr = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_state", {16'h0, ack_v[k], err_v[k], busy_v[k], rd_v[k], maddr_v[k], data_v[k]}, 64'h0);
        end
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        errors = 0; checks = 0; cyc = 0;
        rst_n = 1'b0; cmd = 1'b0; flush = 1'b0; addr = 32'h0;
        for (int i = 0; i < NW; i++) mem[i] = {16'(i), ~16'(i)};
        mem[5] = 32'h0050_0093;

        // Directed vectors for the WAIT_STATES=2 instance, one per cycle.
        //          cmd   flush addr          ack   err   busy  rd    maddr  data
        tbl[0]  = '{1'b1, 1'b0, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0014, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0000_0014, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_0014, 1'b0, 1'b0, 1'b1, 1'b1, 12'd5, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_0014, 1'b0, 1'b0, 1'b1, 1'b0, 12'd5, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 12'd5, 32'h0050_0093};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0, 12'd5, 32'h0050_0093};
        tbl[7]  = '{1'b1, 1'b0, 32'h0001_0000, 1'b1, 1'b1, 1'b1, 1'b0, 12'd5, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 12'd5, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0, 12'd5, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 12'd5, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 12'd5, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b1, 12'd2, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 12'd2, 32'h0};
        tbl[14] = '{1'b1, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 1'b0, 12'd2, 32'h0002_FFFD};
        tbl[15] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'd2, 32'h0002_FFFD};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            cmd = tbl[i].cmd; flush = tbl[i].flush; addr = tbl[i].addr;
            sample();
            check($sformatf("vec%0d", i),
                  {16'h0, ack_v[0], err_v[0], busy_v[0], rd_v[0], maddr_v[0], data_v[0]},
                  {16'h0, tbl[i].ack, tbl[i].err, tbl[i].busy, tbl[i].rd, tbl[i].maddr, tbl[i].data});
            advance();
        end

        // Zero wait states, request held: acks in cycles 3, 6, 9.
        idle(4);
        cmd = 1'b1; addr = 32'h0;
        for (int c = 0; c < 12; c++) begin
            sample();
            check("b2b_ack", {63'h0, ack_v[1]}, {63'h0, (c == 3 || c == 6 || c == 9)});
            if (c == 3 || c == 6 || c == 9) begin
                check("b2b_data", {32'h0, data_v[1]}, {32'h0, mem[c/3 - 1]});
                addr = addr + 32'd4;
                if (c == 9) cmd = 1'b0;
            end
            advance();
        end

        // Flush in WAIT (1), ISSUE (3) and DATA (4) of the two-wait instance.
        flist[0] = 1; flist[1] = 3; flist[2] = 4;
        for (int r = 0; r < 3; r++) begin
            idle(4);
            for (int c = 0; c < 8; c++) begin
                cmd = (c == 0); addr = 32'h0000_0014; flush = (c == flist[r]);
                sample();
                if (c == 0) held = e_data[0];
                check("flush_noack", {63'h0, ack_v[0]}, 64'h0);
                check("flush_data", {32'h0, data_v[0]}, {32'h0, held});
                if (c == flist[r] + 1) check("flush_idle", {63'h0, busy_v[0]}, 64'h0);
                advance();
            end
            cmd = 1'b1; addr = 32'h0000_0014; flush = 1'b0; got = 1'b0;
            for (int c = 0; c < 12 && !got; c++) begin
                sample();
                if (ack_v[0] === 1'b1) begin
                    got = 1'b1;
                    check("flush_next_data", {32'h0, data_v[0]}, {32'h0, 32'h0050_0093});
                    cmd = 1'b0;
                end
                advance();
            end
            check("flush_next_ack", {63'h0, got}, 64'h1);
            cmd = 1'b0;
        end

        // Reset dropped while the two-wait instance is in DATA.
        idle(4);
        cmd = 1'b1; addr = 32'h0000_0014;
        for (int c = 0; c < 4; c++) begin
            sample();
            advance();
        end
        rst_n = 1'b0; cmd = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_async", {16'h0, ack_v[k], err_v[k], busy_v[k], rd_v[k], maddr_v[k], data_v[k]}, 64'h0);
        end
        do_reset();
        for (int c = 0; c < 8; c++) begin
            sample();
            check("rst_noack", {62'h0, ack_v}, 64'h0);
            advance();
        end

        // Randomized traffic against the model, including window edges.
        for (int i = 0; i < 800; i++) begin
            cmd   = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0, 1, 2: addr = 32'($urandom_range(0, NW - 1)) << 2;
                3:       addr = (32'($urandom_range(0, NW - 1)) << 2) + 32'($urandom_range(1, 3));
                4:       addr = $urandom | 32'h0000_4000;
                default: addr = ($urandom_range(0, 1) == 0) ? 32'h0000_3FFC : 32'h0000_4000;
            endcase
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
